// File: rtl/spiker_pkg.sv
// Shared definitions for the spike encoder: LFSR geometry, encoder state
// encoding and the per-channel seed derivation.
package spiker_pkg;

    localparam int LFSR_W = 16;
    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } enc_state_t;

    function automatic logic [LFSR_W-1:0] rotl_seed(input logic [LFSR_W-1:0] seed,
                                                    input int amt);
        logic [LFSR_W-1:0] s;
        int r;
        s = seed;
        r = amt % LFSR_W;
        for (int k = 0; k < LFSR_W; k++) begin
            if (k < r) s = {s[LFSR_W-2:0], s[LFSR_W-1]};
        end
        return s;
    endfunction

endpackage

// File: rtl/spike_lfsr.sv
// 16-bit Fibonacci LFSR that steps only when enabled; exposes its low
// OUT_W bits as the random value compared against a pixel intensity.
module spike_lfsr
    import spiker_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED  = 16'hACE1,
    parameter int                OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    output logic [OUT_W-1:0] o_q
);

    logic [LFSR_W-1:0] r_lfsr;
    logic              w_fb;

    assign w_fb = ^(r_lfsr & LFSR_TAPS);

    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= SEED;
        end else if (i_en) begin
            r_lfsr <= {r_lfsr[LFSR_W-2:0], w_fb};
        end
    end

    assign o_q = r_lfsr[OUT_W-1:0];

endmodule

// File: rtl/spike_encoder.sv
// Rate-coding input stage: turns one latched intensity vector into N_STEPS
// pseudo-random spike vectors, advancing one step per consumed sample.
module spike_encoder
    import spiker_pkg::*;
#(
    parameter int                N_INPUTS   = 4,
    parameter int                PIXEL_W    = 8,
    parameter int                N_STEPS    = 16,
    parameter int                STEP_CNT_W = 5,
    parameter logic [LFSR_W-1:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         pix_valid,
    output logic                         pix_ready,
    input  logic [N_INPUTS*PIXEL_W-1:0]  pix_data,
    input  logic                         abort,
    input  logic                         sample,
    output logic                         sample_ready,
    output logic [N_INPUTS-1:0]          spikes,
    output logic                         done
);

    localparam logic [STEP_CNT_W-1:0] LAST_STEP = STEP_CNT_W'(N_STEPS - 1);

    enc_state_t                    r_state, w_next_state;
    logic [N_INPUTS*PIXEL_W-1:0]   r_int;
    logic [STEP_CNT_W-1:0]         r_step;
    logic [N_INPUTS-1:0]           r_spikes;
    logic                          r_sample_ready;
    logic                          r_done;

    logic                          w_accept, w_advance, w_finish, w_lfsr_en;
    logic [N_INPUTS*PIXEL_W-1:0]   w_src;
    logic [N_INPUTS-1:0]           w_next_spikes;

    // In IDLE the vector being accepted is still on pix_data, not yet latched.
    assign w_src     = (r_state == IDLE) ? pix_data : r_int;
    assign w_lfsr_en = w_accept | w_advance;

    for (genvar g = 0; g < N_INPUTS; g++) begin : g_ch
        logic [PIXEL_W-1:0] w_rnd;
        logic [PIXEL_W-1:0] w_pix;

        spike_lfsr #(
            .SEED (rotl_seed(LFSR_SEED, g)),
            .OUT_W(PIXEL_W)
        ) u_lfsr (
            .clk  (clk),
            .rst_n(rst_n),
            .i_en (w_lfsr_en),
            .o_q  (w_rnd)
        );

        assign w_pix            = w_src[g*PIXEL_W +: PIXEL_W];
        assign w_next_spikes[g] = (w_rnd < w_pix) | (&w_pix);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_advance    = 1'b0;
        w_finish     = 1'b0;
        if (abort) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE: if (pix_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = RUN;
                end
                RUN: if (sample) begin
                    if (r_step == LAST_STEP) begin
                        w_finish     = 1'b1;
                        w_next_state = IDLE;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_int          <= '0;
            r_step         <= '0;
            r_spikes       <= '0;
            r_sample_ready <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (abort || w_finish) begin
                r_spikes       <= '0;
                r_sample_ready <= 1'b0;
                r_step         <= '0;
            end else if (w_accept) begin
                r_int          <= pix_data;
                r_spikes       <= w_next_spikes;
                r_step         <= '0;
                r_sample_ready <= 1'b1;
            end else if (w_advance) begin
                r_spikes <= w_next_spikes;
                r_step   <= r_step + STEP_CNT_W'(1);
            end
        end
    end

    assign pix_ready    = (r_state == IDLE);
    assign sample_ready = r_sample_ready;
    assign spikes       = r_spikes;
    assign done         = r_done;

endmodule

// File: tb/tb_spike_encoder.sv
// Self-checking bench for spike_encoder: hand-computed first-vector table
// plus directed multi-cycle sequences checked against an LFSR model.
module tb_spike_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_valid;
    logic        pix_ready;
    logic [31:0] pix_data;
    logic        abort;
    logic        sample;
    logic        sample_ready;
    logic [3:0]  spikes;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] m_lfsr [4];
    logic [31:0] m_int;

    typedef struct {
        logic [31:0] pix;
        logic [3:0]  exp_spikes;
    } vec_t;

    vec_t tbl [6];

    spike_encoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .abort       (abort),
        .sample      (sample),
        .sample_ready(sample_ready),
        .spikes      (spikes),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Seeds are ACE1 rotated left by the channel index.
    task automatic m_reset();
        m_lfsr[0] = 16'hACE1;
        m_lfsr[1] = 16'h59C3;
        m_lfsr[2] = 16'hB386;
        m_lfsr[3] = 16'h670D;
        m_int     = '0;
    endtask

    task automatic m_advance();
        for (int i = 0; i < 4; i++)
            m_lfsr[i] = {m_lfsr[i][14:0], m_lfsr[i][15] ^ m_lfsr[i][13] ^ m_lfsr[i][12] ^ m_lfsr[i][10]};
    endtask

    function automatic logic [3:0] m_spikes(input logic [31:0] pix);
        logic [3:0] r;
        logic [7:0] v;
        for (int i = 0; i < 4; i++) begin
            v    = pix[i*8 +: 8];
            r[i] = (v == 8'hFF) || (m_lfsr[i][7:0] < v);
        end
        return r;
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        pix_valid = 1'b0;
        pix_data  = '0;
        abort     = 1'b0;
        sample    = 1'b0;
        m_reset();
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Accept pix, then consume all 16 steps; sample either held or pulsed
    // with an idle cycle between pulses. Ends in the cycle done is high.
    task automatic run_image(input logic [31:0] pix, input bit held, input string tag);
        logic [3:0] exp;
        pix_valid = 1'b1;
        pix_data  = pix;
        step();
        pix_valid = 1'b0;
        exp   = m_spikes(pix);
        m_int = pix;
        m_advance();
        for (int k = 0; k < 16; k++) begin
            check({tag, " vec"}, 32'(spikes), 32'(exp));
            check({tag, " sready"}, 32'(sample_ready), 32'h1);
            if (!held) begin
                step();
                check({tag, " stable"}, 32'(spikes), 32'(exp));
            end
            sample = 1'b1;
            step();
            if (!held) sample = 1'b0;
            if (k < 15) begin
                exp = m_spikes(m_int);
                m_advance();
            end
        end
        check({tag, " done"}, 32'(done), 32'h1);
        check({tag, " end sready"}, 32'(sample_ready), 32'h0);
        check({tag, " end spikes"}, 32'(spikes), 32'h0);
        check({tag, " end pix_ready"}, 32'(pix_ready), 32'h1);
    endtask

    initial begin
        logic [3:0] exp;

        tbl[0] = '{32'h0000_0000, 4'h0};
        tbl[1] = '{32'hFFFF_FFFF, 4'hF};
        tbl[2] = '{32'h8080_8080, 4'h8};   // only ch3 (seed low 0D) below 80
        tbl[3] = '{32'h0E87_C4E2, 4'hF};   // each one above its seed low byte
        tbl[4] = '{32'h0D86_C3E1, 4'h0};   // equal to seed low byte: strict compare
        tbl[5] = '{32'h0101_01FE, 4'h1};

        // Reset state, while held and after release with no activity.
        rst_n = 1'b0; pix_valid = 1'b0; pix_data = '0; abort = 1'b0; sample = 1'b0;
        #3;
        check("rst spikes", 32'(spikes), 32'h0);
        check("rst sready", 32'(sample_ready), 32'h0);
        check("rst done", 32'(done), 32'h0);
        check("rst pix_ready", 32'(pix_ready), 32'h1);
        do_reset();
        step(); step();
        check("idle spikes", 32'(spikes), 32'h0);
        check("idle sready", 32'(sample_ready), 32'h0);
        check("idle pix_ready", 32'(pix_ready), 32'h1);

        // First vector after reset, hand-computed from the seeds.
        for (int t = 0; t < 6; t++) begin
            do_reset();
            pix_valid = 1'b1;
            pix_data  = tbl[t].pix;
            step();
            pix_valid = 1'b0;
            check($sformatf("tbl%0d spikes", t), 32'(spikes), 32'(tbl[t].exp_spikes));
            check($sformatf("tbl%0d sready", t), 32'(sample_ready), 32'h1);
            check($sformatf("tbl%0d pix_ready", t), 32'(pix_ready), 32'h0);
        end

        // All-zero image, pulsed samples.
        do_reset();
        run_image(32'h0000_0000, 1'b0, "zero");
        step();
        check("zero done pulse", 32'(done), 32'h0);
        check("zero sready after", 32'(sample_ready), 32'h0);

        // All-ones image, sample held; extra samples ignored afterwards.
        run_image(32'hFFFF_FFFF, 1'b1, "ones");
        step(); step();
        check("ones done pulse", 32'(done), 32'h0);
        check("ones sready after", 32'(sample_ready), 32'h0);
        check("ones spikes after", 32'(spikes), 32'h0);
        sample = 1'b0;

        // Mixed intensities, back-to-back images accepted in the done cycle;
        // LFSR sequence continues across images.
        run_image(32'h4080_C010, 1'b1, "mix0");
        run_image(32'h4080_C010, 1'b1, "mix1");
        run_image(32'h20E0_7F01, 1'b1, "mix2");
        sample = 1'b0;
        step();

        // pix_valid during RUN is ignored; abort with sample at step 5.
        pix_valid = 1'b1; pix_data = 32'h4080_C010;
        step();
        exp = m_spikes(32'h4080_C010); m_int = 32'h4080_C010; m_advance();
        pix_data = 32'hFFFF_FFFF;
        for (int k = 0; k < 5; k++) begin
            check("run pix_ready", 32'(pix_ready), 32'h0);
            check("run vec", 32'(spikes), 32'(exp));
            sample = 1'b1;
            step();
            exp = m_spikes(m_int); m_advance();
        end
        check("pre-abort vec", 32'(spikes), 32'(exp));
        pix_valid = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0; sample = 1'b0;
        check("abort pix_ready", 32'(pix_ready), 32'h1);
        check("abort sready", 32'(sample_ready), 32'h0);
        check("abort spikes", 32'(spikes), 32'h0);
        check("abort done", 32'(done), 32'h0);
        step();
        check("abort no done", 32'(done), 32'h0);

        // abort with pix_valid in IDLE: image not accepted.
        abort = 1'b1; pix_valid = 1'b1; pix_data = 32'h4080_C010;
        step();
        abort = 1'b0; pix_valid = 1'b0;
        check("abort idle pix_ready", 32'(pix_ready), 32'h1);
        check("abort idle sready", 32'(sample_ready), 32'h0);
        step();
        check("abort idle still", 32'(sample_ready), 32'h0);

        // LFSRs kept their value through both aborts.
        run_image(32'h4080_C010, 1'b0, "post-abort");
        step();

        // Async reset at step 7, then the first image reproduces from seeds.
        do_reset();
        pix_valid = 1'b1; pix_data = 32'h4080_C010;
        step();
        pix_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            sample = 1'b1;
            step();
        end
        sample = 1'b0;
        check("pre-rst sready", 32'(sample_ready), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst spikes", 32'(spikes), 32'h0);
        check("midrst sready", 32'(sample_ready), 32'h0);
        check("midrst pix_ready", 32'(pix_ready), 32'h1);
        m_reset();
        step();
        rst_n = 1'b1;
        step();
        run_image(32'h4080_C010, 1'b1, "after-rst");
        sample = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
